// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the RAM2Kx32 port shared by dm_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the RAM.
interface dm_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;

    logic          mem_cen;
    logic          mem_wen;
    logic          mem_oen;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_cen, mem_wen, mem_oen, mem_a, mem_d,
        input  mem_q
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_cen, mem_wen, mem_oen, mem_a, mem_d,
        output mem_q
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data RAM; one access per cycle.
// Default is fixed priority to port 0 with a MAX_WAIT starvation override; define DM_ARB_RR_EN for round-robin.
module dm_arbiter #(
    parameter int AW       = 11,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dm_arbiter_if.slave   bus
);

    logic          w_gnt0;
    logic          w_gnt1;
    logic [1:0]    r_rd_own;
    logic [1:0]    w_rd_own_nxt;

    logic          w_mem_cen;
    logic          w_mem_wen;
    logic [AW-1:0] w_mem_a;
    logic [DW-1:0] w_mem_d;

`ifdef DM_ARB_RR_EN
    // One-hot record of the last winner; all-zero after reset lets port 0 take the first tie.
    logic [1:0] r_last_gnt;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            if (bus.p0_req && bus.p1_req) begin
                if (r_last_gnt == 2'b01) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
            end else begin
                w_gnt0 = bus.p0_req;
                w_gnt1 = bus.p1_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 2'b00;
        end else if (w_gnt0) begin
            r_last_gnt <= 2'b01;
        end else if (w_gnt1) begin
            r_last_gnt <= 2'b10;
        end
    end
`else
    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic       w_force_p1;

    assign w_force_p1 = (r_wait_cnt >= LP_MAX_WAIT);

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            w_gnt0 = bus.p0_req && !(bus.p1_req && w_force_p1);
            w_gnt1 = bus.p1_req && (!bus.p0_req || w_force_p1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (!bus.p1_req || w_gnt1) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != 4'd15) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end
`endif

    always_comb begin
        w_mem_cen = 1'b1;
        w_mem_wen = 1'b1;
        w_mem_a   = '0;
        w_mem_d   = '0;
        if (w_gnt0) begin
            w_mem_cen = 1'b0;
            w_mem_wen = ~bus.p0_we;
            w_mem_a   = bus.p0_addr;
            w_mem_d   = bus.p0_wdata;
        end else if (w_gnt1) begin
            w_mem_cen = 1'b0;
            w_mem_wen = ~bus.p1_we;
            w_mem_a   = bus.p1_addr;
            w_mem_d   = bus.p1_wdata;
        end
    end

    always_comb begin
        w_rd_own_nxt = 2'b00;
        if (w_gnt0 && !bus.p0_we) begin
            w_rd_own_nxt = 2'b01;
        end else if (w_gnt1 && !bus.p1_we) begin
            w_rd_own_nxt = 2'b10;
        end
    end

    // Owner of the RAM read data arriving next cycle; writes and idle cycles clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_own <= 2'b00;
        end else begin
            r_rd_own <= w_rd_own_nxt;
        end
    end

    assign bus.p0_gnt    = w_gnt0;
    assign bus.p1_gnt    = w_gnt1;
    assign bus.p0_rvalid = r_rd_own[0];
    assign bus.p1_rvalid = r_rd_own[1];
    assign bus.p0_rdata  = r_rd_own[0] ? bus.mem_q : '0;
    assign bus.p1_rdata  = r_rd_own[1] ? bus.mem_q : '0;

    assign bus.mem_cen = w_mem_cen;
    assign bus.mem_wen = w_mem_wen;
    assign bus.mem_oen = ~(|r_rd_own);
    assign bus.mem_a   = w_mem_a;
    assign bus.mem_d   = w_mem_d;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural one-cycle-latency RAM behind it.
// Expected values are hand-computed; the contention table follows DM_ARB_RR_EN.
module tb_dm_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   numCompared;
    int   numMismatched;

    logic [DW-1:0] ram [2048];

    dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dm_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write at the enabling edge, read data on mem_q one cycle later.
    always @(posedge clk) begin
        if (!bus.mem_cen) begin
            if (!bus.mem_wen) begin
                ram[bus.mem_a] <= bus.mem_d;
            end else begin
                bus.mem_q <= ram[bus.mem_a];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic r1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.p0_req   = r0;
        bus.p0_we    = we0;
        bus.p0_addr  = a0;
        bus.p0_wdata = d0;
        bus.p1_req   = r1;
        bus.p1_we    = we1;
        bus.p1_addr  = a1;
        bus.p1_wdata = d1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_p0_gnt"}, 32'(bus.p0_gnt), 32'd0);
        checkOutput({tag, "_p1_gnt"}, 32'(bus.p1_gnt), 32'd0);
        checkOutput({tag, "_mem_cen"}, 32'(bus.mem_cen), 32'd1);
        checkOutput({tag, "_mem_wen"}, 32'(bus.mem_wen), 32'd1);
        checkOutput({tag, "_mem_a"}, 32'(bus.mem_a), 32'd0);
        checkOutput({tag, "_mem_d"}, bus.mem_d, 32'd0);
    endtask

    initial begin
        bit [9:0] contSeq;
        logic     prevP1;

        numCompared   = 0;
        numMismatched = 0;
        bus.mem_q     = '0;
        for (int i = 0; i < 2048; i++) begin
            ram[i] = 32'hA500_0000 | 32'(i);
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;

        // Reset values while held in reset
        @(negedge clk);
        @(negedge clk);
        #1;
        checkIdleOutputs("rst");
        checkOutput("rst_mem_oen", 32'(bus.mem_oen), 32'd1);
        checkOutput("rst_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
        checkOutput("rst_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
        rst_n = 1'b1;

        // Reset asserted in the middle of a port 0 read
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 11'h010, '0, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("midrd_p0_gnt_before", 32'(bus.p0_gnt), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midrd");
        checkOutput("midrd_mem_oen", 32'(bus.mem_oen), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("midrd_p0_rvalid_in_rst", 32'(bus.p0_rvalid), 32'd0);
        checkOutput("midrd_p0_rdata_in_rst", bus.p0_rdata, 32'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midrd_p0_rvalid_after", 32'(bus.p0_rvalid), 32'd0);
        checkOutput("midrd_mem_oen_after", 32'(bus.mem_oen), 32'd1);

        // Continuous contention, both ports reading
`ifdef DM_ARB_RR_EN
        contSeq = 10'b10_1010_1010;
`else
        contSeq = 10'b10_0001_0000;
`endif
        prevP1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 11'h020, '0, 1'b1, 1'b0, 11'h030, '0);
            #1;
            checkOutput($sformatf("cont%0d_p0_gnt", i), 32'(bus.p0_gnt), 32'(!contSeq[i]));
            checkOutput($sformatf("cont%0d_p1_gnt", i), 32'(bus.p1_gnt), 32'(contSeq[i]));
            checkOutput($sformatf("cont%0d_mem_a", i), 32'(bus.mem_a), contSeq[i] ? 32'h030 : 32'h020);
            if (i > 0) begin
                checkOutput($sformatf("cont%0d_p0_rvalid", i), 32'(bus.p0_rvalid), 32'(!prevP1));
                checkOutput($sformatf("cont%0d_p1_rvalid", i), 32'(bus.p1_rvalid), 32'(prevP1));
                checkOutput($sformatf("cont%0d_p0_rdata", i), bus.p0_rdata, prevP1 ? 32'd0 : 32'hA500_0020);
                checkOutput($sformatf("cont%0d_p1_rdata", i), bus.p1_rdata, prevP1 ? 32'hA500_0030 : 32'd0);
            end
            prevP1 = contSeq[i];
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("cont_end_p1_rvalid", 32'(bus.p1_rvalid), 32'd1);
        checkOutput("cont_end_p1_rdata", bus.p1_rdata, 32'hA500_0030);
        checkOutput("cont_end_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);

        // Port 0 write then read back
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 11'h010, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("wr_p0_gnt", 32'(bus.p0_gnt), 32'd1);
        checkOutput("wr_mem_cen", 32'(bus.mem_cen), 32'd0);
        checkOutput("wr_mem_wen", 32'(bus.mem_wen), 32'd0);
        checkOutput("wr_mem_a", 32'(bus.mem_a), 32'h010);
        checkOutput("wr_mem_d", bus.mem_d, 32'hDEAD_BEEF);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 11'h010, '0, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("rd_p0_gnt", 32'(bus.p0_gnt), 32'd1);
        checkOutput("rd_mem_wen", 32'(bus.mem_wen), 32'd1);
        checkOutput("rd_mem_oen_after_wr", 32'(bus.mem_oen), 32'd1);
        checkOutput("rd_p0_rvalid_after_wr", 32'(bus.p0_rvalid), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("rd_p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
        checkOutput("rd_p0_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
        checkOutput("rd_mem_oen", 32'(bus.mem_oen), 32'd0);
        checkOutput("rd_p1_rdata", bus.p1_rdata, 32'd0);
        checkOutput("rd_mem_cen_idle", 32'(bus.mem_cen), 32'd1);

        // Back-to-back mixed: p1 read 7FF, p0 write 000, p1 read 000
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h7FF, '0);
        #1;
        checkOutput("b2b1_p1_gnt", 32'(bus.p1_gnt), 32'd1);
        checkOutput("b2b1_mem_a", 32'(bus.mem_a), 32'h7FF);
        checkOutput("b2b1_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 11'h000, 32'h1234_5678, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("b2b2_p0_gnt", 32'(bus.p0_gnt), 32'd1);
        checkOutput("b2b2_mem_wen", 32'(bus.mem_wen), 32'd0);
        checkOutput("b2b2_p1_rvalid", 32'(bus.p1_rvalid), 32'd1);
        checkOutput("b2b2_p1_rdata", bus.p1_rdata, 32'hA500_07FF);
        checkOutput("b2b2_mem_oen", 32'(bus.mem_oen), 32'd0);
        checkOutput("b2b2_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h000, '0);
        #1;
        checkOutput("b2b3_p1_gnt", 32'(bus.p1_gnt), 32'd1);
        checkOutput("b2b3_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
        checkOutput("b2b3_mem_oen", 32'(bus.mem_oen), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("b2b4_p1_rvalid", 32'(bus.p1_rvalid), 32'd1);
        checkOutput("b2b4_p1_rdata", bus.p1_rdata, 32'h1234_5678);
        checkOutput("b2b4_p0_rdata", bus.p0_rdata, 32'd0);

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checkIdleOutputs($sformatf("idle%0d", i));
            checkOutput($sformatf("idle%0d_mem_oen", i), 32'(bus.mem_oen), 32'd1);
            checkOutput($sformatf("idle%0d_p0_rvalid", i), 32'(bus.p0_rvalid), 32'd0);
            checkOutput($sformatf("idle%0d_p1_rvalid", i), 32'(bus.p1_rvalid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
